// File: rtl/multicycle_cu.sv
// Multi-cycle control unit: sequences fetch/decode/execute/memory/writeback over a
// req/ack memory handshake, owns the N/Z flags, counts retired instructions, faults on memory timeout.
module multicycle_cu #(
   parameter int MEM_TIMEOUT = 16,
   parameter int CNT_W       = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [2:0]       op_code,
   input  logic [2:0]       branch,
   input  logic [1:0]       alu_flags,
   input  logic             im_ack,
   input  logic             dm_ack,
   output logic             im_req,
   output logic             dm_req,
   output logic             dm_we,
   output logic             ir_we,
   output logic             pc_we,
   output logic             pc_sel,
   output logic [1:0]       alu_op,
   output logic             rf_we,
   output logic             writeback_sel,
   output logic             rtype_sel,
   output logic             rs2_sel,
   output logic [1:0]       flags,
   output logic             retire,
   output logic [CNT_W-1:0] instret,
   output logic             fault,
   output logic             busy
);

   typedef enum logic [2:0] {
      S_BOOT, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_FAULT
   } state_t;

   localparam logic [2:0] OP_ADD = 3'd0, OP_SUB = 3'd1, OP_OR  = 3'd2, OP_AND = 3'd3,
                          OP_CMP = 3'd4, OP_LDR = 3'd5, OP_STR = 3'd6, OP_BR  = 3'd7;
   localparam logic [1:0] ALU_ADD = 2'd0, ALU_SUB = 2'd1;

   // Counter only ever holds 0..MEM_TIMEOUT-1; the cycle that would reach MEM_TIMEOUT leaves for FAULT.
   localparam int              WC_W    = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
   localparam logic [WC_W-1:0] TO_LAST = WC_W'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);

   state_t           r_state, w_next;
   logic [2:0]       r_op, r_br;
   logic [1:0]       r_flags;
   logic [CNT_W-1:0] r_instret;
   logic [WC_W-1:0]  r_wcnt;

   logic w_wait, w_ack, w_to, w_taken, w_flag_we;

   assign w_wait = (r_state == S_FETCH) || (r_state == S_MEM);
   assign w_ack  = (r_state == S_FETCH) ? im_ack : dm_ack;
   assign w_to   = (MEM_TIMEOUT > 0) && w_wait && !w_ack && (r_wcnt == TO_LAST);

   // flags = {N,Z}; conditions use the registered copy, never the live ALU flags
   always_comb begin
      case (r_br)
         3'd0:    w_taken = r_flags[0];
         3'd1:    w_taken = !r_flags[0];
         3'd2:    w_taken = r_flags[1];
         3'd3:    w_taken = !r_flags[1];
         3'd4:    w_taken = 1'b1;
         default: w_taken = 1'b0;
      endcase
   end

   always_comb begin
      w_next        = r_state;
      w_flag_we     = 1'b0;
      im_req        = 1'b0;
      dm_req        = 1'b0;
      dm_we         = 1'b0;
      ir_we         = 1'b0;
      pc_we         = 1'b0;
      pc_sel        = 1'b0;
      alu_op        = ALU_ADD;
      rf_we         = 1'b0;
      writeback_sel = 1'b0;
      rtype_sel     = 1'b0;
      rs2_sel       = 1'b0;
      retire        = 1'b0;
      case (r_state)
         S_BOOT: w_next = S_FETCH;
         S_FETCH: begin
            im_req = 1'b1;
            if (im_ack) begin
               ir_we  = 1'b1;
               w_next = S_DECODE;
            end else if (w_to) begin
               w_next = S_FAULT;
            end
         end
         S_DECODE: w_next = S_EXEC;
         S_EXEC: begin
            case (r_op)
               OP_ADD, OP_SUB, OP_OR, OP_AND: begin
                  alu_op    = r_op[1:0];
                  rf_we     = 1'b1;
                  w_flag_we = 1'b1;
                  pc_we     = 1'b1;
                  retire    = 1'b1;
                  w_next    = S_FETCH;
               end
               OP_CMP: begin
                  alu_op    = ALU_SUB;
                  w_flag_we = 1'b1;
                  pc_we     = 1'b1;
                  retire    = 1'b1;
                  w_next    = S_FETCH;
               end
               OP_BR: begin
                  pc_we  = 1'b1;
                  pc_sel = w_taken;
                  retire = 1'b1;
                  w_next = S_FETCH;
               end
               default: w_next = S_MEM;
            endcase
         end
         S_MEM: begin
            dm_req = 1'b1;
            if (r_op == OP_STR) begin
               dm_we   = 1'b1;
               rs2_sel = 1'b1;
            end
            if (dm_ack) begin
               if (r_op == OP_STR) begin
                  pc_we  = 1'b1;
                  retire = 1'b1;
                  w_next = S_FETCH;
               end else begin
                  w_next = S_WB;
               end
            end else if (w_to) begin
               w_next = S_FAULT;
            end
         end
         S_WB: begin
            rf_we         = 1'b1;
            writeback_sel = 1'b1;
            rtype_sel     = 1'b1;
            pc_we         = 1'b1;
            retire        = 1'b1;
            w_next        = S_FETCH;
         end
         S_FAULT: w_next = S_FAULT;
         default: w_next = S_BOOT;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= S_BOOT;
         r_op      <= OP_ADD;
         r_br      <= 3'd0;
         r_flags   <= 2'b00;
         r_instret <= '0;
         r_wcnt    <= '0;
      end else begin
         r_state <= w_next;
         if (r_state == S_DECODE) begin
            r_op <= op_code;
            r_br <= branch;
         end
         if (w_flag_we) r_flags <= alu_flags;
         if (retire) r_instret <= r_instret + CNT_W'(1);
         // clears whenever we are not stalled in a request state, so each FETCH/MEM entry starts at 0
         if ((MEM_TIMEOUT > 0) && w_wait && !w_ack && !w_to) r_wcnt <= r_wcnt + WC_W'(1);
         else                                                r_wcnt <= '0;
      end
   end

   assign flags   = r_flags;
   assign instret = r_instret;
   assign fault   = (r_state == S_FAULT);
   assign busy    = (r_state != S_BOOT) && (r_state != S_FAULT);

endmodule
